// File: rtl/spi_resp_pkg.sv
// Shared types and helpers for the SPI sensor responder.
// Holds the FSM state encoding, default frame geometry and the frame builder.
package spi_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_LEAD_ZEROS = 3;
  localparam int DEF_FRAME_LEN  = 16;

  // Widest frame the builder can produce; callers truncate to their FRAME_LEN.
  localparam int MAX_FRAME_LEN  = 64;

  // Place the value below the leading zeros and above the trailing zeros.
  // Bit FRAME_LEN-1 of the truncated result is the first bit on the wire.
  function automatic logic [MAX_FRAME_LEN-1:0] build_frame(
    input logic [MAX_FRAME_LEN-1:0] value,
    input int                       trail
  );
    return value << trail;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI input, followed by a
// single edge-detect flop. level/rise/fall appear SYNC_STAGES+1 clk cycles
// after the pin changes (counting the registered action in the consumer).
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw pin into the chain and remember the previous synchronized level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-detect registers; reset to the line's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_sensor_responder.sv
// SPI mode-0 responder emulating the ambient-light sensor ADC frame.
// Each cs-low window shifts {LEAD_ZEROS zeros, value, trailing zeros} out on
// miso, MSB first, advancing on synchronized sclk falling edges.
// Optional build macro SPI_RESP_FRAME_CNT_EN adds frame_count and overrun.
//
// Handshake: sample_data is transferred on any clk edge where sample_valid
// and sample_ready are both high; sample_ready is high exactly while the
// one-entry holding register is empty. A frame start empties the holding
// register on the same edge, and a value accepted on that edge is kept for
// the following frame.
module spi_sensor_responder
  import spi_resp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEAD_ZEROS  = DEF_LEAD_ZEROS,
  parameter int FRAME_LEN   = DEF_FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              sclk,
  input  logic              cs,
  output logic              miso,
  output logic              miso_oe,
  output logic              frame_done,
`ifdef SPI_RESP_FRAME_CNT_EN
  output logic [15:0]       frame_count,
  output logic              overrun,
`endif
  output logic              frame_abort
);

  localparam int                 IDX_W    = $clog2(FRAME_LEN);
  localparam int                 TRAIL    = FRAME_LEN - LEAD_ZEROS - DATA_W;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e                 state_q, state_d;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_W-1:0]      last_q, last_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  logic [DATA_W-1:0]      frame_val;

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_fall;
  // The master samples on sclk rising edges; the responder has no use for
  // them or for the raw synchronized sclk level.
  logic sclk_level_unused, sclk_rise_unused;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise_unused),
    .fall  (sclk_fall)
  );

  // cs idles high, so its synchronizer resets high to avoid a false frame start.
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (cs),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Next-state, frame loading/shifting and holding-register handshake.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    frame_val   = hold_full_q ? hold_q : last_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          // Fresh value if one is waiting, otherwise repeat the last one.
          last_d      = frame_val;
          hold_full_d = 1'b0;
          shift_d     = FRAME_LEN'(build_frame(MAX_FRAME_LEN'(frame_val), TRAIL));
          idx_d       = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_lvl) begin
          // In SHIFT cs was low, so a high level here is its rising edge.
          state_d = ST_IDLE;
          abort_d = cs_rise;
        end else if (sclk_fall) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = {shift_q[FRAME_LEN-2:0], 1'b0};
          end
        end
      end
      ST_DONE: begin
        if (cs_lvl) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Uses the pre-frame-start fullness, so a same-edge offer waits a cycle
    // when the register was full and lands for the next frame otherwise.
    if (sample_valid && !hold_full_q) begin
      hold_d      = sample_data;
      hold_full_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign miso_oe      = (state_q != ST_IDLE);
  assign miso         = (state_q == ST_SHIFT) & shift_q[FRAME_LEN-1];
  assign frame_done   = done_q;
  assign frame_abort  = abort_q;

`ifdef SPI_RESP_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic        overrun_q, overrun_d;

  // Count completed frames (wrapping) and flag any frame that had to repeat.
  always_comb begin
    frame_count_d = frame_count_q + (done_d ? 16'd1 : 16'd0);
    overrun_d     = overrun_q | ((state_q == ST_IDLE) & cs_fall & ~hold_full_q);
  end

  // Statistics registers; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;
`endif

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Bench for spi_sensor_responder: acts as a mode-0 SPI master at sclk=clk/8,
// keeps a frame-level behavioural model and checks every cycle.
module tb_spi_sensor_responder;

  localparam int S  = 2;
  localparam int FL = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_data = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       miso, miso_oe, frame_done, frame_abort;
`ifdef SPI_RESP_FRAME_CNT_EN
  logic [15:0] frame_count;
  logic        overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int abort_seen = 0;

  always #5 clk = ~clk;

  spi_sensor_responder #(.SYNC_STAGES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sclk         (sclk),
    .cs           (cs),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .frame_done   (frame_done),
`ifdef SPI_RESP_FRAME_CNT_EN
    .frame_count  (frame_count),
    .overrun      (overrun),
`endif
    .frame_abort  (frame_abort)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pin history: index i holds the pin as sampled i+1 edges ago, so the
  // responder reacts to a pin change on the (S+1)th edge after it.
  logic [S:0]  cs_h = '1;
  logic [S:0]  sclk_h = '0;
  logic [7:0]  m_hold = 8'h00, m_last = 8'h00, m_v;
  bit          m_full = 0, m_active = 0, m_acc;
  int          m_falls = 0;
  logic [15:0] m_frame = 16'h0;
  bit          m_done = 0, m_abort = 0, m_ovr = 0;
  logic [15:0] m_cnt = 16'h0;
  logic [7:0]  exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      cs_h = '1; sclk_h = '0;
      m_hold = 8'h00; m_last = 8'h00; m_full = 0; m_active = 0; m_falls = 0;
      m_frame = 16'h0; m_done = 0; m_abort = 0; m_ovr = 0; m_cnt = 16'h0;
    end else begin
      m_acc = sample_valid && !m_full;
      m_done = 0; m_abort = 0;
      if (cs_h[S-1]) begin
        if (m_active && m_falls < FL) m_abort = 1;
        m_active = 0;
      end else if (cs_h[S]) begin
        m_v = m_full ? m_hold : m_last;
        if (!m_full) m_ovr = 1;
        m_last = m_v; m_full = 0;
        m_frame = 16'(m_v) << 5;
        m_active = 1; m_falls = 0;
        exp_q.push_back(m_v);
      end else if (m_active && !sclk_h[S-1] && sclk_h[S] && m_falls < FL) begin
        m_falls++;
        if (m_falls == FL) begin m_done = 1; m_cnt = m_cnt + 16'd1; end
      end
      if (m_acc) begin m_hold = sample_data; m_full = 1; end
      cs_h   = {cs_h[S-1:0], cs};
      sclk_h = {sclk_h[S-1:0], sclk};
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    logic exp_miso;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_miso = (m_active && m_falls < FL) ? m_frame[15 - m_falls] : 1'b0;
      check("miso", 32'(miso), 32'(exp_miso));
      check("miso_oe", 32'(miso_oe), 32'(m_active));
      check("sample_ready", 32'(sample_ready), 32'(!m_full));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("frame_abort", 32'(frame_abort), 32'(m_abort));
`ifdef SPI_RESP_FRAME_CNT_EN
      check("frame_count", 32'(frame_count), 32'(m_cnt));
      check("overrun", 32'(overrun), 32'(m_ovr));
`endif
      if (frame_done === 1'b1) done_seen++;
      if (frame_abort === 1'b1) abort_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  int          exp_rd = 0;
  logic [31:0] last_cap = 32'h0;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] d);
    bit ok;
    ok = 0;
    sample_valid = 1'b1;
    sample_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (sample_ready) ok = 1;
      wait_clks(1);
    end
    sample_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL offer_timeout: sample_ready never high for 0x%0h, expected handshake within 50 cycles", d);
    end
  endtask

  task automatic sclk_pulse(output logic b);
    b = miso;
    sclk = 1'b1;
    wait_clks(4);
    sclk = 1'b0;
    wait_clks(4);
  endtask

  // One cs-low window with the given number of sclk pulses; optionally
  // offers late_d on the edge where the responder sees cs fall.
  task automatic run_frame(input int pulses, input bit late, input logic [7:0] late_d);
    logic [31:0] cap, ef, ecap;
    logic [7:0]  v;
    logic        b;
    cs = 1'b0;
    if (late) begin
      wait_clks(S);
      sample_valid = 1'b1;
      sample_data  = late_d;
      wait_clks(2);
      sample_valid = 1'b0;
    end else begin
      wait_clks(4);
    end
    cap = 32'h0;
    for (int i = 0; i < pulses; i++) begin
      sclk_pulse(b);
      cap = {cap[30:0], b};
    end
    cs = 1'b1;
    wait_clks(6);
    if (exp_rd >= exp_q.size()) begin
      n_checks++; n_fail++;
      $display("FAIL frame_start: no frame start seen, expected one");
    end else begin
      v = exp_q[exp_rd];
      exp_rd++;
      ef = 32'(v) << 5;
      ecap = (pulses <= FL) ? (ef >> (FL - pulses)) : (ef << (pulses - FL));
      check("frame_bits", cap, ecap);
    end
    last_cap = cap;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, a0, np;
    logic b;
    logic [7:0] rv;

    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_miso_oe", 32'(miso_oe), 32'd0);
    check("reset_ready", 32'(sample_ready), 32'd1);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_abort", 32'(frame_abort), 32'd0);

    // First frame with 0xA5
    offer(8'hA5);
    check("ready_after_offer", 32'(sample_ready), 32'd0);
    d0 = done_seen;
    run_frame(16, 0, 8'h00);
    check("frame_a5", last_cap, 32'h14A0);
    check("done_once_a5", 32'(done_seen - d0), 32'd1);
    check("ready_after_frame", 32'(sample_ready), 32'd1);

    // Repeat of 0xA5 with nothing offered
    run_frame(16, 0, 8'h00);
    check("frame_repeat", last_cap, 32'h14A0);
`ifdef SPI_RESP_FRAME_CNT_EN
    check("overrun_lit", 32'(overrun), 32'd1);
    check("frame_count_lit", 32'(frame_count), 32'd2);
`endif

    // Abort after 6 sclk edges while sending 0x3C
    offer(8'h3C);
    a0 = abort_seen;
    run_frame(3, 0, 8'h00);
    check("abort_once", 32'(abort_seen - a0), 32'd1);
    check("abort_prefix", last_cap, 32'h0);
    offer(8'h11);
    run_frame(16, 0, 8'h00);
    check("frame_11", last_cap, 32'h0220);

    // Offer on the same edge as the synchronized cs fall, 0x42 held
    offer(8'h42);
    run_frame(16, 1, 8'h77);
    check("frame_42", last_cap, 32'h0840);
    run_frame(16, 0, 8'h00);
    check("frame_77", last_cap, 32'h0EE0);

    // 20 pulses in one window with 0xFF
    offer(8'hFF);
    d0 = done_seen;
    run_frame(20, 0, 8'h00);
    check("frame_ff_20", last_cap, 32'h1FE00);
    check("done_once_ff", 32'(done_seen - d0), 32'd1);

    // Reset in the middle of a frame with 0x99 pending
    cs = 1'b0;
    wait_clks(4);
    sclk_pulse(b);
    sclk_pulse(b);
    offer(8'h99);
    sclk_pulse(b);
    rst = 1'b1; cs = 1'b1; sclk = 1'b0;
    wait_clks(2);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    rst = 1'b0;
    wait_clks(4);
    exp_rd = exp_q.size();
    run_frame(16, 0, 8'h00);
    check("frame_after_rst", last_cap, 32'h0);

    // Randomized frames: random values, random offers, occasional aborts
    for (int r = 0; r < 10; r++) begin
      rv = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) offer(rv);
      np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
      run_frame(np, 0, 8'h00);
    end

    check("frames_consumed", 32'(exp_q.size() - exp_rd), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
